// File: rtl/sync_down_counter.sv
// Loadable, enable-gated down counter with an IDLE/RUN/DONE control FSM and a one-cycle borrow pulse.
// Define DOWN_CNT_RELOAD_EN to build a free-running reload divider instead of a one-shot timer.
module sync_down_counter #(
  parameter int              WIDTH   = 4,
  parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             start,
  input  logic             en,
  output logic [WIDTH-1:0] count,
  output logic             zero,
  output logic             borrow,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] count_reg, count_next;
  logic             borrow_reg, borrow_next;
  logic             busy_reg;

`ifdef DOWN_CNT_RELOAD_EN
  logic [WIDTH-1:0] reload_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reload_reg <= RST_VAL;
    end else if (load) begin
      reload_reg <= load_val;
    end
  end
`endif

  // load beats start beats en in every state
  always_comb begin
    state_next  = state_reg;
    count_next  = count_reg;
    borrow_next = 1'b0;
    if (load) begin
      count_next = load_val;
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) state_next = RUN;
        end
        RUN: begin
          if (en) begin
            if (count_reg == '0) begin
              borrow_next = 1'b1;
`ifdef DOWN_CNT_RELOAD_EN
              count_next  = reload_reg;
`else
              state_next  = DONE;
`endif
            end else begin
              count_next = count_reg - WIDTH'(1);
            end
          end
        end
        DONE: begin
          state_next = DONE;
        end
        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      count_reg  <= RST_VAL;
      borrow_reg <= 1'b0;
      busy_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      count_reg  <= count_next;
      borrow_reg <= borrow_next;
      busy_reg   <= (state_next == RUN);
    end
  end

  assign count  = count_reg;
  assign zero   = (count_reg == '0);
  assign borrow = borrow_reg;
  assign busy   = busy_reg;

endmodule

// File: tb/tb_sync_down_counter.sv
// Self-checking bench for sync_down_counter: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a behavioural model.
module tb_sync_down_counter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       load = 1'b0;
  logic [3:0] load_val = 4'd0;
  logic       start = 1'b0;
  logic       en = 1'b0;
  logic [3:0] count;
  logic       zero, borrow, busy;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  sync_down_counter #(.WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .load_val(load_val),
    .start(start), .en(en), .count(count), .zero(zero),
    .borrow(borrow), .busy(busy)
  );

  always #5 clk = ~clk;

  // behavioural model: mode 0 = idle, 1 = running, 2 = finished
  int         m_mode   = 0;
  logic [3:0] m_count  = 4'hF;
  logic [3:0] m_reload = 4'hF;
  bit         m_borrow = 1'b0;

  always @(negedge rst_n) begin
    m_mode = 0; m_count = 4'hF; m_reload = 4'hF; m_borrow = 1'b0;
  end

  always @(posedge clk) begin
    if (rst_n) begin
      m_borrow = 1'b0;
      if (load) begin
        m_count = load_val; m_reload = load_val; m_mode = 0;
      end else if (m_mode == 0 && start) begin
        m_mode = 1;
      end else if (m_mode == 1 && en) begin
        if (m_count == 0) begin
          m_borrow = 1'b1;
`ifdef DOWN_CNT_RELOAD_EN
          m_count = m_reload;
`else
          m_mode = 2;
`endif
        end else begin
          m_count = m_count - 4'd1;
        end
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_count",  int'(count),  int'(m_count));
      check("model_zero",   int'(zero),   int'(m_count == 0));
      check("model_borrow", int'(borrow), int'(m_borrow));
      check("model_busy",   int'(busy),   int'(m_mode == 1));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (2) cyc();
    check("reset_count", int'(count), 15);
    check("reset_zero", int'(zero), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_borrow", int'(borrow), 0);
    rst_n = 1'b1;
    chk_en = 1'b1;
    cyc();

    // load 5, start, count to terminal
    load = 1'b1; load_val = 4'd5; cyc();
    check("t2_loaded", int'(count), 5);
    load = 1'b0; start = 1'b1; en = 1'b1; cyc();
    check("t2_entry_count", int'(count), 5);
    check("t2_entry_busy", int'(busy), 1);
    start = 1'b0;
    for (int i = 4; i >= 0; i--) begin
      cyc();
      check("t2_count", int'(count), i);
      check("t2_no_borrow", int'(borrow), 0);
    end
    cyc();
    check("t2_borrow", int'(borrow), 1);
`ifdef DOWN_CNT_RELOAD_EN
    check("t6_reload_count", int'(count), 5);
    check("t6_busy", int'(busy), 1);
`else
    check("t2_done_count", int'(count), 0);
    check("t2_done_zero", int'(zero), 1);
    check("t2_done_busy", int'(busy), 0);
`endif
    cyc();
    check("t2_borrow_pulse", int'(borrow), 0);
`ifndef DOWN_CNT_RELOAD_EN
    start = 1'b1; cyc(); cyc();
    check("t2_done_start_ignored", int'(busy), 0);
    check("t2_done_hold", int'(count), 0);
    start = 1'b0;
`endif

    // run at 7, en pattern 1,0,0,1
    load = 1'b1; load_val = 4'd8; cyc();
    load = 1'b0; start = 1'b1; en = 1'b1; cyc();
    start = 1'b0; cyc();
    check("t3_at7", int'(count), 7);
    cyc(); check("t3_en1", int'(count), 6);
    en = 1'b0;
    cyc(); check("t3_en0a", int'(count), 6);
    cyc(); check("t3_en0b", int'(count), 6);
    en = 1'b1;
    cyc(); check("t3_en1b", int'(count), 5);
    check("t3_borrow", int'(borrow), 0);

    // abort from RUN with load+start together
    load = 1'b1; load_val = 4'd10; cyc();
    load = 1'b0; start = 1'b1; cyc(); cyc();
    check("t4_at9", int'(count), 9);
    load = 1'b1; load_val = 4'd3; start = 1'b1; en = 1'b0; cyc();
    check("t4_loaded", int'(count), 3);
    check("t4_busy", int'(busy), 0);
    load = 1'b0; start = 1'b0; cyc();
    check("t4_idle", int'(busy), 0);

    // asynchronous reset mid-cycle while running
    load = 1'b1; load_val = 4'd5; cyc();
    load = 1'b0; start = 1'b1; en = 1'b1; cyc(); start = 1'b0; cyc();
    check("t5_at4", int'(count), 4);
    #2 rst_n = 1'b0;
    #1;
    check("t5_async_count", int'(count), 15);
    check("t5_async_busy", int'(busy), 0);
    check("t5_async_zero", int'(zero), 0);
    cyc(); rst_n = 1'b1;
    start = 1'b1; en = 1'b1; cyc();
    check("t5_start15", int'(count), 15);
    start = 1'b0; cyc();
    check("t5_dec14", int'(count), 14);

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        rst_n = 1'b0; load = 1'b0; start = 1'b0; cyc(); rst_n = 1'b1;
      end
      load     = ($urandom_range(0, 19) == 0);
      load_val = 4'($urandom);
      start    = ($urandom_range(0, 3) == 0);
      en       = ($urandom_range(0, 3) != 0);
      cyc();
    end
    load = 1'b0; start = 1'b0; en = 1'b0;
    cyc();
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
